// File: rtl/led_matrix_scanner.sv
// Refresh engine for a 16x32 active-low LED matrix: fetches one row from the
// tiled frame buffer, shifts it out to the column drivers, latches it and lights it.
module led_matrix_scanner #(
    parameter logic [31:0] FRAME_BASE = 32'h0000_0000,
    parameter int          ROW_HOLD   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  frame_sel,
    output logic [31:0] mem_a,
    output logic        mem_cs,
    input  logic [31:0] mem_rd,
    output logic        col_sdo,
    output logic        col_sclk,
    output logic        col_latch,
    output logic [3:0]  row_sel,
    output logic        row_oe_n,
    output logic        frame_done
);

    localparam int HOLD_W = (ROW_HOLD > 1) ? $clog2(ROW_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(ROW_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT,
        LATCH,
        DISPLAY
    } state_t;

    state_t            state_q;
    logic [3:0]        frame_q;
    logic [3:0]        row_q;
    logic [1:0]        tile_q;
    logic [4:0]        bit_q;
    logic              phase_q;
    logic [HOLD_W-1:0] hold_q;
    logic [31:0]       shift_q;

    logic [31:0]       mem_a_q;
    logic              mem_cs_q;
    logic              col_sdo_q;
    logic              col_sclk_q;
    logic              col_latch_q;
    logic [3:0]        row_sel_q;
    logic              row_oe_n_q;
    logic              frame_done_q;

    logic [7:0]        rowByte_d;
    logic [31:0]       assembled_d;
    logic [3:0]        nextRow_d;

    // Word k of a tile packs rows k, k+4, k+8, k+12 as consecutive bytes.
    function automatic logic [31:0] wordAddr(input logic [3:0] frame,
                                             input logic [3:0] row,
                                             input logic [1:0] tile);
        return FRAME_BASE + {22'd0, frame, tile, row[1:0], 2'b00};
    endfunction

    always_comb begin
        rowByte_d = mem_rd[7:0];
        case (row_q[3:2])
            2'd0:    rowByte_d = mem_rd[7:0];
            2'd1:    rowByte_d = mem_rd[15:8];
            2'd2:    rowByte_d = mem_rd[23:16];
            default: rowByte_d = mem_rd[31:24];
        endcase
    end

    assign assembled_d = {shift_q[23:0], rowByte_d};
    assign nextRow_d   = row_q + 4'd1;

    // Every output is a register written only here; the first column bit is
    // placed on col_sdo as FETCH ends so it has a full cycle of setup.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            frame_q      <= 4'd0;
            row_q        <= 4'd0;
            tile_q       <= 2'd0;
            bit_q        <= 5'd0;
            phase_q      <= 1'b0;
            hold_q       <= '0;
            shift_q      <= 32'd0;
            mem_a_q      <= 32'd0;
            mem_cs_q     <= 1'b1;
            col_sdo_q    <= 1'b0;
            col_sclk_q   <= 1'b0;
            col_latch_q  <= 1'b0;
            row_sel_q    <= 4'd0;
            row_oe_n_q   <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    mem_cs_q   <= 1'b1;
                    row_oe_n_q <= 1'b1;
                    if (en) begin
                        row_q    <= 4'd0;
                        frame_q  <= frame_sel;
                        tile_q   <= 2'd0;
                        mem_a_q  <= wordAddr(frame_sel, 4'd0, 2'd0);
                        mem_cs_q <= 1'b0;
                        state_q  <= FETCH;
                    end
                end

                FETCH: begin
                    shift_q <= assembled_d;
                    if (tile_q == 2'd3) begin
                        mem_cs_q   <= 1'b1;
                        col_sdo_q  <= assembled_d[31];
                        col_sclk_q <= 1'b0;
                        bit_q      <= 5'd0;
                        phase_q    <= 1'b0;
                        state_q    <= SHIFT;
                    end else begin
                        tile_q  <= tile_q + 2'd1;
                        mem_a_q <= wordAddr(frame_q, row_q, tile_q + 2'd1);
                    end
                end

                SHIFT: begin
                    if (!phase_q) begin
                        col_sclk_q <= 1'b1;
                        phase_q    <= 1'b1;
                    end else begin
                        col_sclk_q <= 1'b0;
                        phase_q    <= 1'b0;
                        if (bit_q == 5'd31) begin
                            col_latch_q <= 1'b1;
                            row_sel_q   <= row_q;
                            state_q     <= LATCH;
                        end else begin
                            shift_q   <= {shift_q[30:0], 1'b0};
                            col_sdo_q <= shift_q[30];
                            bit_q     <= bit_q + 5'd1;
                        end
                    end
                end

                LATCH: begin
                    col_latch_q <= 1'b0;
                    row_oe_n_q  <= 1'b0;
                    hold_q      <= '0;
                    state_q     <= DISPLAY;
                end

                DISPLAY: begin
                    if (hold_q == HOLD_LAST) begin
                        row_oe_n_q <= 1'b1;
                        hold_q     <= '0;
                        if (row_q != 4'd15) begin
                            row_q    <= nextRow_d;
                            tile_q   <= 2'd0;
                            mem_a_q  <= wordAddr(frame_q, nextRow_d, 2'd0);
                            mem_cs_q <= 1'b0;
                            state_q  <= FETCH;
                        end else begin
                            frame_done_q <= 1'b1;
                            if (en) begin
                                row_q    <= 4'd0;
                                frame_q  <= frame_sel;
                                tile_q   <= 2'd0;
                                mem_a_q  <= wordAddr(frame_sel, 4'd0, 2'd0);
                                mem_cs_q <= 1'b0;
                                state_q  <= FETCH;
                            end else begin
                                state_q <= IDLE;
                            end
                        end
                    end else begin
                        hold_q <= hold_q + HOLD_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_a      = mem_a_q;
    assign mem_cs     = mem_cs_q;
    assign col_sdo    = col_sdo_q;
    assign col_sclk   = col_sclk_q;
    assign col_latch  = col_latch_q;
    assign row_sel    = row_sel_q;
    assign row_oe_n   = row_oe_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: a passive monitor logs bus activity,
// and one task per scenario compares the log against hand-derived values.
module tb_led_matrix_scanner;

    localparam int HOLD = 5;
    localparam int ROW_PERIOD = 69 + HOLD;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  frame_sel = 4'd0;
    logic [31:0] mem_a;
    logic        mem_cs;
    logic [31:0] mem_rd;
    logic        col_sdo;
    logic        col_sclk;
    logic        col_latch;
    logic [3:0]  row_sel;
    logic        row_oe_n;
    logic        frame_done;

    logic [31:0] mem [0:255];

    int checks = 0;
    int passes = 0;

    led_matrix_scanner #(
        .FRAME_BASE(32'h0000_0000),
        .ROW_HOLD  (HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .frame_sel (frame_sel),
        .mem_a     (mem_a),
        .mem_cs    (mem_cs),
        .mem_rd    (mem_rd),
        .col_sdo   (col_sdo),
        .col_sclk  (col_sclk),
        .col_latch (col_latch),
        .row_sel   (row_sel),
        .row_oe_n  (row_oe_n),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];

    // Monitor state: written only by the monitor, read by the test tasks.
    int          cycle = 0;
    logic [31:0] addrQ[$];
    int          addrCycQ[$];
    logic [31:0] latchWordQ[$];
    logic [3:0]  latchRowQ[$];
    int          sclkPerRowQ[$];
    int          latchGapQ[$];
    int          oeFallGapQ[$];
    int          dwellQ[$];
    int          frameDoneCycQ[$];
    int          frameDoneCount = 0;
    int          rowSelUnstable = 0;
    int          sdoErr = 0;
    int          rowSclk = 0;
    logic [31:0] serial = 32'd0;
    int          lastSclkCyc = 0;
    int          latchCyc = 0;
    logic        inDwell = 1'b0;
    int          dwellLen = 0;
    logic [3:0]  dwellRow = 4'd0;
    logic        prevSdo = 1'b0;
    logic        prevSclk = 1'b0;

    always @(negedge clk) begin
        cycle = cycle + 1;
        if (reset) begin
            rowSclk  = 0;
            serial   = 32'd0;
            inDwell  = 1'b0;
            dwellLen = 0;
        end else begin
            if (!mem_cs) begin
                addrQ.push_back(mem_a);
                addrCycQ.push_back(cycle);
            end
            if (col_sclk) begin
                if (prevSclk || (col_sdo !== prevSdo)) sdoErr = sdoErr + 1;
                serial      = {serial[30:0], col_sdo};
                rowSclk     = rowSclk + 1;
                lastSclkCyc = cycle;
            end
            if (col_latch) begin
                latchWordQ.push_back(serial);
                latchRowQ.push_back(row_sel);
                sclkPerRowQ.push_back(rowSclk);
                latchGapQ.push_back(cycle - lastSclkCyc);
                latchCyc = cycle;
                rowSclk  = 0;
            end
            if (!row_oe_n) begin
                if (!inDwell) begin
                    oeFallGapQ.push_back(cycle - latchCyc);
                    dwellRow = row_sel;
                end
                inDwell  = 1'b1;
                dwellLen = dwellLen + 1;
                if (row_sel !== dwellRow) rowSelUnstable = rowSelUnstable + 1;
            end else if (inDwell) begin
                dwellQ.push_back(dwellLen);
                inDwell  = 1'b0;
                dwellLen = 0;
            end
            if (frame_done) begin
                frameDoneCount = frameDoneCount + 1;
                frameDoneCycQ.push_back(cycle);
            end
        end
        prevSdo  = col_sdo;
        prevSclk = col_sclk;
    end

    task automatic stepCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        en    = 1'b0;
        repeat (3) stepCycle();
        reset = 1'b0;
        stepCycle();
    endtask

    task automatic fillOnes();
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
        mem[4] = 32'hDBC3_81FF;
    endtask

    task automatic fillPattern();
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            b = 8'(i);
            mem[i] = {b ^ 8'hA5, b ^ 8'h5A, b + 8'h11, b};
        end
    endtask

    // Row word model: tile 0's byte ends up in the top byte.
    function automatic logic [31:0] expRow(input int f, input int r);
        logic [31:0] w;
        logic [31:0] acc;
        acc = 32'd0;
        for (int t = 0; t < 4; t++) begin
            w   = mem[f * 16 + t * 4 + (r % 4)];
            acc = {acc[23:0], 8'((w >> (8 * (r / 4))) & 32'hFF)};
        end
        return acc;
    endfunction

    function automatic logic [31:0] expAddr(input int f, input int r, input int t);
        return 32'((f * 16 + t * 4 + (r % 4)) * 4);
    endfunction

    task automatic test_reset();
        int ab;
        reset = 1'b1;
        en = 1'b0; stepCycle();
        en = 1'b1; stepCycle();
        en = 1'b0; stepCycle();
        en = 1'b1; stepCycle();
        checks++; if (mem_a !== 32'd0) $display("[TB] FAIL reset_mem_a got %h want 0", mem_a); else passes++;
        checks++; if (mem_cs !== 1'b1) $display("[TB] FAIL reset_mem_cs got %b want 1", mem_cs); else passes++;
        checks++; if (col_sdo !== 1'b0) $display("[TB] FAIL reset_col_sdo got %b want 0", col_sdo); else passes++;
        checks++; if (col_sclk !== 1'b0) $display("[TB] FAIL reset_col_sclk got %b want 0", col_sclk); else passes++;
        checks++; if (col_latch !== 1'b0) $display("[TB] FAIL reset_col_latch got %b want 0", col_latch); else passes++;
        checks++; if (row_sel !== 4'd0) $display("[TB] FAIL reset_row_sel got %0d want 0", row_sel); else passes++;
        checks++; if (row_oe_n !== 1'b1) $display("[TB] FAIL reset_row_oe_n got %b want 1", row_oe_n); else passes++;
        checks++; if (frame_done !== 1'b0) $display("[TB] FAIL reset_frame_done got %b want 0", frame_done); else passes++;
        en = 1'b0;
        reset = 1'b0;
        ab = addrQ.size();
        repeat (10) stepCycle();
        checks++; if (mem_cs !== 1'b1) $display("[TB] FAIL idle_mem_cs got %b want 1", mem_cs); else passes++;
        checks++; if (row_oe_n !== 1'b1) $display("[TB] FAIL idle_row_oe_n got %b want 1", row_oe_n); else passes++;
        checks++; if (addrQ.size() !== ab) $display("[TB] FAIL idle_no_fetch got %0d fetches want 0", addrQ.size() - ab); else passes++;
    endtask

    task automatic test_fetch_addresses();
        int ab, t0;
        logic [31:0] want [4];
        want = '{32'h84, 32'h94, 32'hA4, 32'hB4};
        applyReset();
        fillPattern();
        frame_sel = 4'd2;
        ab = addrQ.size();
        t0 = cycle;
        en = 1'b1;
        for (int i = 0; i < 1000 && addrQ.size() < ab + 24; i++) stepCycle();
        checks++; if (addrQ.size() < ab + 24) $display("[TB] FAIL fetch_timeout got %0d fetches want 24", addrQ.size() - ab); else passes++;
        checks++; if (addrCycQ[ab] - t0 !== 1) $display("[TB] FAIL startup_latency got %0d want 1", addrCycQ[ab] - t0); else passes++;
        checks++; if (addrQ[ab] !== 32'h80) $display("[TB] FAIL first_addr got %h want 00000080", addrQ[ab]); else passes++;
        for (int t = 0; t < 4; t++) begin
            checks++;
            if (addrQ[ab + 20 + t] !== want[t])
                $display("[TB] FAIL row5_addr_t%0d got %h want %h", t, addrQ[ab + 20 + t], want[t]);
            else passes++;
        end
        checks++; if (addrCycQ[ab + 23] - addrCycQ[ab + 20] !== 3) $display("[TB] FAIL row5_consecutive got span %0d want 3", addrCycQ[ab + 23] - addrCycQ[ab + 20]); else passes++;
        checks++; if (addrCycQ[ab + 4] - addrCycQ[ab] !== ROW_PERIOD) $display("[TB] FAIL row_period got %0d want %0d", addrCycQ[ab + 4] - addrCycQ[ab], ROW_PERIOD); else passes++;
    endtask

    task automatic test_row_assembly();
        int lb, db, gb, ub, sb;
        applyReset();
        fillOnes();
        frame_sel = 4'd0;
        lb = latchWordQ.size(); db = dwellQ.size(); gb = oeFallGapQ.size();
        ub = rowSelUnstable; sb = sdoErr;
        en = 1'b1;
        for (int i = 0; i < 1000 && latchWordQ.size() < lb + 5; i++) stepCycle();
        checks++; if (latchWordQ.size() < lb + 5) $display("[TB] FAIL latch_timeout got %0d latches want 5", latchWordQ.size() - lb); else passes++;
        checks++; if (latchWordQ[lb + 4] !== 32'hFF81_FFFF) $display("[TB] FAIL row4_stream got %h want ff81ffff", latchWordQ[lb + 4]); else passes++;
        checks++; if (latchWordQ[lb + 3] !== 32'hFFFF_FFFF) $display("[TB] FAIL row3_stream got %h want ffffffff", latchWordQ[lb + 3]); else passes++;
        checks++; if (sclkPerRowQ[lb + 4] !== 32) $display("[TB] FAIL row4_sclk_pulses got %0d want 32", sclkPerRowQ[lb + 4]); else passes++;
        checks++; if (latchGapQ[lb + 4] !== 1) $display("[TB] FAIL latch_after_sclk got %0d want 1", latchGapQ[lb + 4]); else passes++;
        checks++; if (latchRowQ[lb + 4] !== 4'd4) $display("[TB] FAIL row4_row_sel got %0d want 4", latchRowQ[lb + 4]); else passes++;
        for (int i = 0; i < 100 && dwellQ.size() < db + 5; i++) stepCycle();
        checks++; if (dwellQ[db + 4] !== HOLD) $display("[TB] FAIL row4_dwell got %0d want %0d", dwellQ[db + 4], HOLD); else passes++;
        checks++; if (oeFallGapQ[gb + 4] !== 1) $display("[TB] FAIL oe_after_latch got %0d want 1", oeFallGapQ[gb + 4]); else passes++;
        checks++; if (rowSelUnstable !== ub) $display("[TB] FAIL row_sel_stable got %0d changes want 0", rowSelUnstable - ub); else passes++;
        checks++; if (sdoErr !== sb) $display("[TB] FAIL sdo_setup got %0d violations want 0", sdoErr - sb); else passes++;
    endtask

    task automatic test_frame_sampling();
        int ab, lb, db, fb, fcb, f, bad;
        logic [31:0] got;
        applyReset();
        fillPattern();
        frame_sel = 4'd1;
        ab = addrQ.size(); lb = latchWordQ.size(); db = dwellQ.size();
        fb = frameDoneCount; fcb = frameDoneCycQ.size();
        en = 1'b1;
        for (int i = 0; i < 1500 && addrQ.size() < ab + 29; i++) stepCycle();
        frame_sel = 4'd3;
        for (int i = 0; i < 3000 && addrQ.size() < ab + 128; i++) stepCycle();
        checks++; if (addrQ.size() < ab + 128) $display("[TB] FAIL frames_timeout got %0d fetches want 128", addrQ.size() - ab); else passes++;
        for (int r = 0; r < 32; r++) begin
            f = (r < 16) ? 1 : 3;
            bad = -1;
            for (int t = 0; t < 4; t++)
                if (bad < 0 && addrQ[ab + r * 4 + t] !== expAddr(f, r % 16, t)) bad = t;
            checks++;
            if (bad >= 0)
                $display("[TB] FAIL frame_addr_row%0d got %h want %h", r, addrQ[ab + r * 4 + bad], expAddr(f, r % 16, bad));
            else passes++;
        end
        for (int i = 0; i < 1500 && frameDoneCount < fb + 2; i++) stepCycle();
        checks++; if (frameDoneCount - fb !== 2) $display("[TB] FAIL frame_done_count got %0d want 2", frameDoneCount - fb); else passes++;
        for (int r = 0; r < 32; r++) begin
            f = (r < 16) ? 1 : 3;
            got = latchWordQ[lb + r];
            checks++;
            if (got !== expRow(f, r % 16) || latchRowQ[lb + r] !== 4'(r % 16))
                $display("[TB] FAIL frame_row%0d got %h/row %0d want %h/row %0d", r, got, latchRowQ[lb + r], expRow(f, r % 16), r % 16);
            else passes++;
        end
        checks++; if (frameDoneCycQ[fcb] !== addrCycQ[ab + 64]) $display("[TB] FAIL back_to_back got done@%0d fetch@%0d want equal", frameDoneCycQ[fcb], addrCycQ[ab + 64]); else passes++;
        checks++; if (frameDoneCycQ[fcb] - addrCycQ[ab] !== 16 * ROW_PERIOD) $display("[TB] FAIL frame_period got %0d want %0d", frameDoneCycQ[fcb] - addrCycQ[ab], 16 * ROW_PERIOD); else passes++;
        checks++; if (frameDoneCycQ[fcb + 1] - frameDoneCycQ[fcb] !== 16 * ROW_PERIOD) $display("[TB] FAIL frame_done_spacing got %0d want %0d", frameDoneCycQ[fcb + 1] - frameDoneCycQ[fcb], 16 * ROW_PERIOD); else passes++;
        bad = 0;
        for (int i = 0; i < 32; i++) if (dwellQ[db + i] !== HOLD) bad++;
        checks++; if (bad !== 0) $display("[TB] FAIL all_dwells got %0d wrong want 0", bad); else passes++;
    endtask

    task automatic test_enable_drop();
        int ab, lb, fb, t0;
        applyReset();
        fillPattern();
        frame_sel = 4'd0;
        ab = addrQ.size(); lb = latchWordQ.size(); fb = frameDoneCount;
        en = 1'b1;
        for (int i = 0; i < 1000 && addrQ.size() < ab + 13; i++) stepCycle();
        en = 1'b0;
        for (int i = 0; i < 1500 && frameDoneCount < fb + 1; i++) stepCycle();
        checks++; if (frame_done !== 1'b1) $display("[TB] FAIL drop_frame_done got %b want 1", frame_done); else passes++;
        checks++; if (mem_cs !== 1'b1) $display("[TB] FAIL drop_no_refetch got mem_cs %b want 1", mem_cs); else passes++;
        checks++; if (latchWordQ.size() - lb !== 16) $display("[TB] FAIL drop_rows_done got %0d want 16", latchWordQ.size() - lb); else passes++;
        repeat (20) stepCycle();
        checks++; if (addrQ.size() - ab !== 64) $display("[TB] FAIL drop_idle_fetches got %0d want 64", addrQ.size() - ab); else passes++;
        checks++; if (frameDoneCount - fb !== 1) $display("[TB] FAIL drop_done_once got %0d want 1", frameDoneCount - fb); else passes++;
        checks++; if (row_oe_n !== 1'b1 || mem_cs !== 1'b1) $display("[TB] FAIL drop_idle_outputs got oe_n %b cs %b want 1 1", row_oe_n, mem_cs); else passes++;
        frame_sel = 4'd4;
        t0 = cycle;
        en = 1'b1;
        repeat (2) stepCycle();
        checks++; if (addrQ[ab + 64] !== 32'h100) $display("[TB] FAIL restart_addr got %h want 00000100", addrQ[ab + 64]); else passes++;
        checks++; if (addrCycQ[ab + 64] - t0 !== 1) $display("[TB] FAIL restart_latency got %0d want 1", addrCycQ[ab + 64] - t0); else passes++;
    endtask

    task automatic test_reset_mid_shift();
        int ab, lb, t0;
        applyReset();
        fillPattern();
        frame_sel = 4'd0;
        lb = latchWordQ.size();
        en = 1'b1;
        for (int i = 0; i < 1000 && latchWordQ.size() < lb + 2; i++) stepCycle();
        for (int i = 0; i < 200 && rowSclk < 10; i++) stepCycle();
        checks++; if (rowSclk !== 10) $display("[TB] FAIL mid_shift_reach got %0d pulses want 10", rowSclk); else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (mem_a !== 32'd0) $display("[TB] FAIL async_mem_a got %h want 0", mem_a); else passes++;
        checks++; if (mem_cs !== 1'b1) $display("[TB] FAIL async_mem_cs got %b want 1", mem_cs); else passes++;
        checks++; if (col_sclk !== 1'b0 || col_sdo !== 1'b0 || col_latch !== 1'b0) $display("[TB] FAIL async_col got sclk %b sdo %b latch %b want 0 0 0", col_sclk, col_sdo, col_latch); else passes++;
        checks++; if (row_sel !== 4'd0) $display("[TB] FAIL async_row_sel got %0d want 0", row_sel); else passes++;
        checks++; if (row_oe_n !== 1'b1 || frame_done !== 1'b0) $display("[TB] FAIL async_row got oe_n %b done %b want 1 0", row_oe_n, frame_done); else passes++;
        repeat (2) stepCycle();
        frame_sel = 4'd5;
        en = 1'b1;
        ab = addrQ.size(); lb = latchWordQ.size();
        t0 = cycle;
        reset = 1'b0;
        for (int i = 0; i < 200 && latchWordQ.size() < lb + 1; i++) stepCycle();
        checks++; if (addrQ[ab] !== 32'h140 || addrCycQ[ab] - t0 !== 1) $display("[TB] FAIL restart_row0 got %h after %0d want 00000140 after 1", addrQ[ab], addrCycQ[ab] - t0); else passes++;
        checks++; if (latchRowQ[lb] !== 4'd0 || sclkPerRowQ[lb] !== 32) $display("[TB] FAIL restart_latch got row %0d pulses %0d want 0 32", latchRowQ[lb], sclkPerRowQ[lb]); else passes++;
        checks++; if (latchWordQ[lb] !== expRow(5, 0)) $display("[TB] FAIL restart_word got %h want %h", latchWordQ[lb], expRow(5, 0)); else passes++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hFFFF_FFFF;
        test_reset();
        test_fetch_addresses();
        test_row_assembly();
        test_frame_sampling();
        test_enable_drop();
        test_reset_mid_shift();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
